// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, memop codes, FSM states
// and the byte-lane helpers used when a transaction is launched.
package mem_access_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int MemOpBus   = 3;

   typedef enum logic [MemOpBus-1:0] {
      MEM_NONE = 3'd0,
      MEM_LB   = 3'd1,
      MEM_LBU  = 3'd2,
      MEM_LW   = 3'd3,
      MEM_SB   = 3'd4,
      MEM_SW   = 3'd5
   } memop_e;

   typedef enum logic {
      STATE_IDLE   = 1'b0,
      STATE_ACCESS = 1'b1
   } state_e;

   function automatic logic is_mem_op(input logic [MemOpBus-1:0] op);
      case (op)
         MEM_LB, MEM_LBU, MEM_LW, MEM_SB, MEM_SW: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

   function automatic logic is_word_op(input logic [MemOpBus-1:0] op);
      return (op == MEM_LW) || (op == MEM_SW);
   endfunction

   function automatic logic is_store(input logic [MemOpBus-1:0] op);
      return (op == MEM_SB) || (op == MEM_SW);
   endfunction

   // Loads use the same byte enables as a store of the same width.
   function automatic logic [3:0] sel_for(input logic [MemOpBus-1:0] op, input logic [1:0] lo);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: return 4'b0001 << lo;
         MEM_LW, MEM_SW:          return 4'hF;
         default:                 return 4'h0;
      endcase
   endfunction

   function automatic logic [RegBus-1:0] wdata_for(input logic [MemOpBus-1:0] op,
                                                   input logic [RegBus-1:0] data);
      case (op)
         MEM_SB:  return {4{data[7:0]}};
         MEM_SW:  return data;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: picks the addressed little-endian byte and
// sign/zero-extends it, or passes a full word through.
module mem_load_align
   import mem_access_pkg::*;
(
   input  logic [MemOpBus-1:0] op,
   input  logic [1:0]          addr_lo,
   input  logic [RegBus-1:0]   rdata,
   output logic [RegBus-1:0]   data
);

   logic [7:0] lane;

   always_comb begin
      case (addr_lo)
         2'd0:    lane = rdata[7:0];
         2'd1:    lane = rdata[15:8];
         2'd2:    lane = rdata[23:16];
         default: lane = rdata[31:24];
      endcase
      case (op)
         MEM_LB:  data = {{24{lane[7]}}, lane};
         MEM_LBU: data = {24'd0, lane};
         MEM_LW:  data = rdata;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results to write-back and runs one req/ack bus
// transaction per load/store. Optional misalignment trap via MEM_ALIGN_CHECK_EN.
module mem_access
   import mem_access_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RegBus-1:0]     ex_wdata_i,
   input  logic [RegAddrBus-1:0] ex_wd_i,
   input  logic                  ex_wreg_i,
   input  logic [MemOpBus-1:0]   ex_memop_i,
   input  logic [RegBus-1:0]     ex_memaddr_i,
   input  logic [RegBus-1:0]     ex_memdata_i,
   output logic                  stall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [RegBus-1:0]     mem_addr_o,
   output logic [3:0]            mem_sel_o,
   output logic [RegBus-1:0]     mem_wdata_o,
   input  logic                  mem_ack_i,
   input  logic [RegBus-1:0]     mem_rdata_i,
   output logic [RegBus-1:0]     wb_wdata_o,
   output logic [RegAddrBus-1:0] wb_wd_o,
   output logic                  wb_wreg_o,
   output logic                  align_err_o
);

   state_e                state;
   memop_e                lat_op;
   logic [RegAddrBus-1:0] lat_wd;
   logic                  lat_wreg;
   logic [RegBus-1:0]     eff_addr;
   logic [RegBus-1:0]     load_data;
   logic                  misaligned;

   // Word accesses always go out word-aligned; when the trap is compiled in,
   // misaligned words never reach the bus anyway.
   assign eff_addr = is_word_op(ex_memop_i) ? {ex_memaddr_i[RegBus-1:2], 2'b00} : ex_memaddr_i;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = is_word_op(ex_memop_i) && (ex_memaddr_i[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign stall_o = (state == STATE_ACCESS);

   mem_load_align u_load_align (
      .op      (lat_op),
      .addr_lo (mem_addr_o[1:0]),
      .rdata   (mem_rdata_i),
      .data    (load_data)
   );

   // Single FSM: launches the bus access from IDLE and retires it on ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= STATE_IDLE;
         lat_op      <= MEM_NONE;
         lat_wd      <= '0;
         lat_wreg    <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_sel_o   <= 4'h0;
         mem_wdata_o <= '0;
         wb_wdata_o  <= '0;
         wb_wd_o     <= '0;
         wb_wreg_o   <= 1'b0;
         align_err_o <= 1'b0;
      end else begin
         align_err_o <= 1'b0;
         case (state)
            STATE_IDLE: begin
               if (is_mem_op(ex_memop_i)) begin
                  wb_wdata_o <= '0;
                  wb_wd_o    <= '0;
                  wb_wreg_o  <= 1'b0;
                  if (misaligned) begin
                     align_err_o <= 1'b1;
                  end else begin
                     state       <= STATE_ACCESS;
                     lat_op      <= memop_e'(ex_memop_i);
                     lat_wd      <= ex_wd_i;
                     lat_wreg    <= ex_wreg_i;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= is_store(ex_memop_i);
                     mem_addr_o  <= eff_addr;
                     mem_sel_o   <= sel_for(ex_memop_i, ex_memaddr_i[1:0]);
                     mem_wdata_o <= wdata_for(ex_memop_i, ex_memdata_i);
                  end
               end else begin
                  wb_wdata_o <= ex_wdata_i;
                  wb_wd_o    <= ex_wd_i;
                  wb_wreg_o  <= ex_wreg_i;
               end
            end
            STATE_ACCESS: begin
               if (mem_ack_i) begin
                  state       <= STATE_IDLE;
                  mem_req_o   <= 1'b0;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= '0;
                  mem_sel_o   <= 4'h0;
                  mem_wdata_o <= '0;
                  if (is_store(lat_op)) begin
                     wb_wdata_o <= '0;
                     wb_wd_o    <= '0;
                     wb_wreg_o  <= 1'b0;
                  end else begin
                     wb_wdata_o <= load_data;
                     wb_wd_o    <= lat_wd;
                     wb_wreg_o  <= lat_wreg;
                  end
               end else begin
                  wb_wdata_o <= '0;
                  wb_wd_o    <= '0;
                  wb_wreg_o  <= 1'b0;
               end
            end
            default: state <= STATE_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage directly downstream of the execute stage: registers the EX result bundle, and for load/store ops runs a single-outstanding req/ack transaction on the data bus before handing the destination register, write enable and write data to write-back. It holds the upstream pipeline with `stall_o` while a transaction is pending and does byte lane selection and load sign/zero extension.

## Interface
Parameters: none (widths come from the shared defines: RegBus = 32, RegAddrBus = 5).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_wdata_i` in 32: ALU result.
- `ex_wd_i` in 5: destination register.
- `ex_wreg_i` in 1: register write enable.
- `ex_memop_i` in 3: memory op code.
- `ex_memaddr_i` in 32: effective address.
- `ex_memdata_i` in 32: store data.
- `stall_o` out 1: hold upstream stages.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: 1 = store.
- `mem_addr_o` out 32: bus address.
- `mem_sel_o` out 4: byte enables; bit k = bits [8k+7:8k].
- `mem_wdata_o` out 32: store data.
- `mem_ack_i` in 1: transaction complete, one cycle.
- `mem_rdata_i` in 32: load data, valid with ack.
- `wb_wdata_o` out 32, `wb_wd_o` out 5, `wb_wreg_o` out 1: registered write-back bundle.
- `align_err_o` out 1: misaligned access pulse. Constant 0 when the check is not compiled in.

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE, op NONE, or any unlisted code**: on the edge, `wb_*` takes the EX values unchanged.
- **IDLE, memory op**:
  - On the edge, latch op, wd, wreg, addr, data. Go to ACCESS.
  - The same edge writes a bubble to write-back (`wb_wreg_o`=0).
- **ACCESS**:
  - `mem_req_o`=1 and `stall_o`=1.
  - `mem_addr_o`, `mem_we_o`, `mem_sel_o` and `mem_wdata_o` are driven from latched values and held stable until ack.
  - No ack: write-back gets a bubble.
- **Ack edge in ACCESS**: go to IDLE.
  - Load: `wb_wdata_o` = extracted data, `wb_wd_o`/`wb_wreg_o` from the latched values.
  - Store: `wb_wreg_o`=0.
- EX inputs are ignored while `stall_o`=1; upstream holds them.
- Little-endian lanes.
  - LB: sign-extend byte addr[1:0]. LBU: zero-extend it. LW: full word.
  - SB: sel = 1<<addr[1:0], wdata = byte replicated ×4. SW: sel = 4'hF, wdata = data.
  - Loads drive the same sel as the equivalent store width.
- `mem_ack_i` outside ACCESS is ignored. There is no timeout; req holds indefinitely.
- Reset, including mid-transaction: state IDLE. `mem_req_o`, `stall_o`, `mem_we_o`, `align_err_o`, `wb_wreg_o` = 0. All data, address and sel outputs = 0. The pending access is abandoned.

## Timing
- Non-memory op: 1-cycle latency EX→write-back.
- Memory op captured at edge N:
  - `mem_req_o` high from cycle N+1.
  - If ack arrives in cycle N+k, the result is visible at write-back after edge N+k.
  - `stall_o` is low from cycle N+k+1. The next EX op is captured at edge N+k+1.
- Zero-wait bus (ack in the first ACCESS cycle): a memory op occupies 2 cycles.
- `stall_o` = (state == ACCESS), decoded from registered state only, with no combinational path from `mem_ack_i`.

## Configuration
- Macro `MEM_ALIGN_CHECK_EN`.
- **Defined**: LW/SW with addr[1:0] ≠ 0 are detected in IDLE. The FSM stays in IDLE and issues no request. Write-back gets a bubble, and `align_err_o` pulses 1 for one cycle after the edge.
- **Undefined**: addr[1:0] are forced to 0 for LW/SW and the access proceeds. `align_err_o` is tied 0.
- Byte ops are never misaligned.

## Structure
- Shared defines/package holds:
  - memop codes: MEM_NONE=0, MEM_LB=1, MEM_LBU=2, MEM_LW=3, MEM_SB=4, MEM_SW=5;
  - state encodings STATE_IDLE, STATE_ACCESS;
  - MemOpBus width.
- One sub-module, `mem_load_align`: purely combinational. Inputs are op, addr[1:0] and rdata; output is the extended 32-bit value. It is unit-testable on its own.

## Test plan
1. **ALU pass-through**: memop NONE, wdata=0x1234_5678, wd=3, wreg=1 → next cycle `wb_*` = 0x12345678/3/1. `mem_req_o` never rises.
2. **LW with 2 wait cycles**: addr 0x100, ack in the third ACCESS cycle with rdata 0xDEADBEEF.
   - `stall_o` and `mem_req_o` high for 3 cycles; sel=F.
   - Then wb = 0xDEADBEEF with wreg=1.
   - The next op is captured only after `stall_o` falls.
3. **Byte loads**: LB addr 0x103, rdata 0x80FF_0000 → wb 0xFFFFFF80. LBU at the same address → 0x00000080. Zero-wait bus: each op occupies exactly 2 cycles.
4. **SB**: addr 0x202, data 0x000000AB → `mem_sel_o`=4'b0100, `mem_wdata_o`=0xABABABAB, `mem_we_o`=1, then `wb_wreg_o`=0.
5. **Reset mid-transaction**: assert `rst` during ACCESS with no ack → `mem_req_o`/`stall_o` drop immediately. After release, IDLE accepts a new op normally; a late ack is ignored.
6. **Misaligned SW** at 0x301:
   - With `MEM_ALIGN_CHECK_EN`: no request, `align_err_o` pulses once.
   - Without it: request issued to 0x300 with sel=F.
